uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_rr_arb2.sv | 18 +
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler:
// FSM encodings, default character geometry and the requester id type.
package uart_tx_arbiter_pkg;

  localparam int DBIT_DEFAULT   = 8;
  localparam int NBYTES_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic {
    REQ_ID_0 = 1'b0,
    REQ_ID_1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module uart_rr_arb2
  import uart_tx_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == REQ_ID_1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two word-sized requesters; the granted
// word is sent LSB character first and the owner is acked after the last one.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DBIT   = DBIT_DEFAULT,
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_req0,
  input  logic [DBIT*NBYTES-1:0] i_word0,
  input  logic                   i_req1,
  input  logic [DBIT*NBYTES-1:0] i_word1,
  output logic                   o_ack0,
  output logic                   o_ack1,
  output logic                   o_busy,
  output logic                   o_tx_start,
  output logic [DBIT-1:0]        o_tx_data,
  input  logic                   i_tx_done
);

  localparam int W  = DBIT * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  logic [1:0]    state;
  logic [W-1:0]  shift_reg;
  logic [CW-1:0] byte_cnt;
  req_id_t       grant_id;
  req_id_t       last_grant;
  logic [1:0]    grant;
  logic [W-1:0]  granted_word;
  logic [W-1:0]  shifted_word;

  uart_rr_arb2 u_arb (
    .req        ({i_req1, i_req0}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign granted_word = grant[0] ? i_word0 : i_word1;
  assign shifted_word = shift_reg >> DBIT;

  // tx_start/tx_data are loaded on the transition into START so the pulse
  // is visible during the START cycle itself.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      byte_cnt   <= '0;
      grant_id   <= REQ_ID_0;
      last_grant <= REQ_ID_1;
      o_ack0     <= 1'b0;
      o_ack1     <= 1'b0;
      o_busy     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_ack0     <= 1'b0;
      o_ack1     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            shift_reg  <= granted_word;
            byte_cnt   <= '0;
            grant_id   <= grant[1] ? REQ_ID_1 : REQ_ID_0;
            o_tx_start <= 1'b1;
            o_tx_data  <= granted_word[DBIT-1:0];
            o_busy     <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done) begin
            if (byte_cnt == LAST_CNT) begin
              o_ack0 <= (grant_id == REQ_ID_0);
              o_ack1 <= (grant_id == REQ_ID_1);
              state  <= ST_DONE;
            end else begin
              shift_reg  <= shifted_word;
              byte_cnt   <= byte_cnt + 1'b1;
              o_tx_start <= 1'b1;
              o_tx_data  <= shifted_word[DBIT-1:0];
              state      <= ST_START;
            end
          end
        end
        ST_DONE: begin
          last_grant <= grant_id;
          o_busy     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model that answers
// each start with a done pulse ten cycles later.
module tb_uart_tx_arbiter;

  localparam int DBIT   = 8;
  localparam int NBYTES = 4;
  localparam int W      = DBIT * NBYTES;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0 = 1'b0;
  logic            req1 = 1'b0;
  logic [W-1:0]    word0 = '0;
  logic [W-1:0]    word1 = '0;
  logic            ack0, ack1, busy, tx_start;
  logic [DBIT-1:0] tx_data;
  logic            tx_done;
  logic            done_model = 1'b0;
  logic            done_force = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0] char_q[$];
  int         ack_q[$];
  int         start_idx_q[$];
  int         ack_idx_q[$];
  int         cyc = 0;
  int         cnt = 0;
  int         last_done_idx = 0;
  int         stab_err = 0;
  logic [7:0] cur_char = '0;

  assign tx_done = done_model | done_force;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DBIT(DBIT), .NBYTES(NBYTES)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_req0     (req0),
    .i_word0    (word0),
    .i_req1     (req1),
    .i_word1    (word1),
    .o_ack0     (ack0),
    .o_ack1     (ack1),
    .o_busy     (busy),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_done  (tx_done)
  );

  // Transmitter model and output logger
  always @(negedge clk) begin
    cyc++;
    done_model = 1'b0;
    if (rst) begin
      cnt = 0;
    end else if (tx_start) begin
      char_q.push_back(tx_data);
      start_idx_q.push_back(cyc);
      cur_char = tx_data;
      cnt = 10;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        done_model = 1'b1;
        last_done_idx = cyc;
      end
    end
    if (ack0) begin ack_q.push_back(0); ack_idx_q.push_back(cyc); end
    if (ack1) begin ack_q.push_back(1); ack_idx_q.push_back(cyc); end
    if (busy && !tx_start && tx_data !== cur_char) stab_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [7:0] exp_char(input logic [W-1:0] word, input int b);
    return 8'(word >> (8 * b));
  endfunction

  function automatic int count_acks(input int id);
    int c = 0;
    foreach (ack_q[i]) if (ack_q[i] == id) c++;
    return c;
  endfunction

  task automatic clear_logs();
    char_q.delete();
    ack_q.delete();
    start_idx_q.delete();
    ack_idx_q.delete();
    stab_err = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Runs until `total` acks arrive; drops each request once it has k acks.
  task automatic run_until(input int k0, input int k1, input int total,
                           input int budget, output int gap, output bit timed_out);
    int n;
    n = 0;
    gap = 0;
    while (ack_q.size() < total && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (ack_q.size() == 1 && !busy) gap++;
      if (count_acks(0) >= k0) req0 = 1'b0;
      if (count_acks(1) >= k1) req1 = 1'b0;
    end
    timed_out = (ack_q.size() < total);
    if (timed_out) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    settle(3);
    tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    rst = 1'b0;
    settle(1);
  endtask

  task automatic test_single();
    int gap, req_idx;
    bit to;
    logic [W-1:0] w;
    w = 32'hA1B2C3D4;
    clear_logs();
    word0 = w;
    req0 = 1'b1;
    req_idx = cyc;
    run_until(1, 99, 1, 300, gap, to);
    settle(20);
    tests++; if (to) begin fails++; $display("FAIL single_timeout: acks %0d want 1", ack_q.size()); end
    tests++;
    if (char_q.size() != 4) begin
      fails++; $display("FAIL single_nchars: got %0d want 4", char_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (char_q[i] !== exp_char(w, i)) begin
          fails++; $display("FAIL single_char%0d: got %h want %h", i, char_q[i], exp_char(w, i));
        end
      end
      tests++;
      if (start_idx_q[0] != req_idx + 1) begin
        fails++; $display("FAIL single_start_latency: got %0d want %0d", start_idx_q[0] - req_idx, 1);
      end
      tests++;
      if (start_idx_q[1] != start_idx_q[0] + 11) begin
        fails++; $display("FAIL single_char_gap: got %0d want 11", start_idx_q[1] - start_idx_q[0]);
      end
    end
    tests++;
    if (ack_q.size() != 1 || count_acks(0) != 1) begin
      fails++; $display("FAIL single_acks: got %0d acks (%0d ack0) want 1 ack0", ack_q.size(), count_acks(0));
    end else begin
      tests++;
      if (ack_idx_q[0] != last_done_idx + 1) begin
        fails++; $display("FAIL single_ack_latency: got %0d want 1", ack_idx_q[0] - last_done_idx);
      end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL single_data_stable: got %0d glitches want 0", stab_err); end
  endtask

  task automatic test_tie();
    int gap;
    bit to;
    logic [W-1:0] ws[2];
    ws[0] = 32'h11223344;
    ws[1] = 32'h55667788;
    rst = 1'b1;
    settle(1);
    rst = 1'b0;
    clear_logs();
    word0 = ws[0];
    word1 = ws[1];
    req0 = 1'b1;
    req1 = 1'b1;
    run_until(1, 1, 2, 600, gap, to);
    settle(20);
    tests++; if (to) begin fails++; $display("FAIL tie_timeout: acks %0d want 2", ack_q.size()); end
    tests++;
    if (ack_q.size() != 2) begin
      fails++; $display("FAIL tie_nacks: got %0d want 2", ack_q.size());
    end else begin
      tests++;
      if (ack_q[0] != 0 || ack_q[1] != 1) begin
        fails++; $display("FAIL tie_ack_order: got %0d,%0d want 0,1", ack_q[0], ack_q[1]);
      end
    end
    tests++;
    if (char_q.size() != 8) begin
      fails++; $display("FAIL tie_nchars: got %0d want 8", char_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (char_q[i] !== exp_char(ws[i/4], i%4)) begin
          fails++; $display("FAIL tie_char%0d: got %h want %h", i, char_q[i], exp_char(ws[i/4], i%4));
        end
      end
      if (ack_idx_q.size() >= 1) begin
        tests++;
        if (start_idx_q[4] != ack_idx_q[0] + 2) begin
          fails++; $display("FAIL tie_regrant_latency: got %0d want 2", start_idx_q[4] - ack_idx_q[0]);
        end
      end
    end
    tests++; if (gap != 1) begin fails++; $display("FAIL tie_idle_gap: got %0d idle cycles want 1", gap); end
  endtask

  task automatic test_contention();
    int gap;
    bit to;
    logic [W-1:0] ws[2];
    ws[0] = 32'h0A0B0C0D;
    ws[1] = 32'h1A1B1C1D;
    clear_logs();
    word0 = ws[0];
    word1 = ws[1];
    req0 = 1'b1;
    req1 = 1'b1;
    run_until(3, 3, 6, 1500, gap, to);
    settle(20);
    tests++; if (to) begin fails++; $display("FAIL cont_timeout: acks %0d want 6", ack_q.size()); end
    tests++;
    if (ack_q.size() != 6) begin
      fails++; $display("FAIL cont_nacks: got %0d want 6", ack_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (ack_q[i] != (i % 2)) begin
          fails++; $display("FAIL cont_grant%0d: got %0d want %0d", i, ack_q[i], i % 2);
        end
      end
    end
    tests++;
    if (char_q.size() != 24) begin
      fails++; $display("FAIL cont_nchars: got %0d want 24", char_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        tests++;
        if (char_q[i] !== exp_char(ws[(i/4)%2], i%4)) begin
          fails++; $display("FAIL cont_char%0d: got %h want %h", i, char_q[i], exp_char(ws[(i/4)%2], i%4));
        end
      end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL cont_data_stable: got %0d glitches want 0", stab_err); end
  endtask

  task automatic test_spurious_done();
    int gap;
    bit to;
    logic [W-1:0] w;
    w = 32'hDEADBEEF;
    clear_logs();
    done_force = 1'b1;
    settle(1);
    done_force = 1'b0;
    settle(3);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL spur_idle_busy: got %b want 0", busy); end
    tests++; if (ack_q.size() != 0) begin fails++; $display("FAIL spur_idle_ack: got %0d acks want 0", ack_q.size()); end
    word0 = w;
    req0 = 1'b1;
    settle(1);
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL spur_start_seen: got %b want 1", tx_start); end
    done_force = 1'b1;
    settle(1);
    done_force = 1'b0;
    run_until(1, 99, 1, 300, gap, to);
    settle(20);
    tests++; if (to) begin fails++; $display("FAIL spur_timeout: acks %0d want 1", ack_q.size()); end
    tests++;
    if (ack_q.size() != 1 || count_acks(0) != 1) begin
      fails++; $display("FAIL spur_acks: got %0d acks want 1 ack0", ack_q.size());
    end
    tests++;
    if (char_q.size() != 4) begin
      fails++; $display("FAIL spur_nchars: got %0d want 4", char_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (char_q[i] !== exp_char(w, i)) begin
          fails++; $display("FAIL spur_char%0d: got %h want %h", i, char_q[i], exp_char(w, i));
        end
      end
    end
  endtask

  task automatic test_word_change();
    int gap;
    bit to;
    logic [W-1:0] w;
    w = 32'h01020304;
    clear_logs();
    word0 = w;
    req0 = 1'b1;
    settle(1);
    word0 = 32'hFFFFFFFF;
    run_until(1, 99, 1, 300, gap, to);
    settle(20);
    tests++; if (to) begin fails++; $display("FAIL wchg_timeout: acks %0d want 1", ack_q.size()); end
    tests++;
    if (char_q.size() != 4) begin
      fails++; $display("FAIL wchg_nchars: got %0d want 4", char_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (char_q[i] !== exp_char(w, i)) begin
          fails++; $display("FAIL wchg_char%0d: got %h want %h", i, char_q[i], exp_char(w, i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int gap, n;
    bit to;
    logic [W-1:0] w;
    clear_logs();
    word0 = 32'hCAFEF00D;
    req0 = 1'b1;
    n = 0;
    while (start_idx_q.size() < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++; if (start_idx_q.size() < 2) begin fails++; $display("FAIL rmid_second_start: got %0d starts want 2", start_idx_q.size()); end
    settle(3);
    rst = 1'b1;
    settle(1);
    tests++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin fails++; $display("FAIL rmid_acks: got %b%b want 00", ack1, ack0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rmid_tx_start: got %b want 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rmid_tx_data: got %h want 00", tx_data); end
    rst = 1'b0;
    req0 = 1'b0;
    settle(20);
    tests++; if (ack_q.size() != 0) begin fails++; $display("FAIL rmid_no_ack: got %0d acks want 0", ack_q.size()); end
    w = 32'h0BADF00D;
    clear_logs();
    word1 = w;
    req1 = 1'b1;
    run_until(99, 1, 1, 300, gap, to);
    settle(20);
    tests++; if (to) begin fails++; $display("FAIL rmid_req1_timeout: acks %0d want 1", ack_q.size()); end
    tests++;
    if (ack_q.size() != 1 || count_acks(1) != 1) begin
      fails++; $display("FAIL rmid_req1_ack: got %0d acks (%0d ack1) want 1 ack1", ack_q.size(), count_acks(1));
    end
    tests++;
    if (char_q.size() != 4) begin
      fails++; $display("FAIL rmid_nchars: got %0d want 4", char_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (char_q[i] !== exp_char(w, i)) begin
          fails++; $display("FAIL rmid_char%0d: got %h want %h", i, char_q[i], exp_char(w, i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_contention();
    test_spurious_done();
    test_word_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
